// File: rtl/fox_packet_assembler.sv
// Packet assembler between the processor's MMIO field registers and a Hoplite
// router injection port: captures fields, commits packets into a FIFO, counts outcomes.
module fox_packet_assembler #(
  parameter int COORD_BITS           = 1,
  parameter int MULTICAST_GROUP_BITS = 1,
  parameter int MATRIX_TYPE_BITS     = 1,
  parameter int MATRIX_COORD_BITS    = 8,
  parameter int MATRIX_ELEMENT_BITS  = 32,
  parameter int FIFO_DEPTH           = 2,
  parameter int COUNT_BITS           = 16,
  parameter int PACKET_BITS          = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 +
                                       MATRIX_TYPE_BITS + 2*MATRIX_COORD_BITS +
                                       MATRIX_ELEMENT_BITS
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [COORD_BITS-1:0]           x_coord_in,
  input  logic                            x_coord_in_valid,
  input  logic [COORD_BITS-1:0]           y_coord_in,
  input  logic                            y_coord_in_valid,
  input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
  input  logic                            multicast_group_in_valid,
  input  logic                            done_flag_in,
  input  logic                            done_flag_in_valid,
  input  logic                            result_flag_in,
  input  logic                            result_flag_in_valid,
  input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
  input  logic                            matrix_type_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
  input  logic                            matrix_x_coord_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
  input  logic                            matrix_y_coord_in_valid,
  input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
  input  logic                            matrix_element_in_valid,
  input  logic                            packet_complete_in,
  output logic                            message_out_ready,
  output logic [PACKET_BITS-1:0]          pkt_out_data,
  output logic                            pkt_out_valid,
  input  logic                            pkt_out_ready,
  output logic [COUNT_BITS-1:0]           sent_count,
  output logic [COUNT_BITS-1:0]           malformed_count,
  output logic [COUNT_BITS-1:0]           dropped_count,
  output logic                            error
);

  localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = PTR_BITS + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
  localparam logic [PTR_BITS-1:0]   PTR_ONE = PTR_BITS'(1);
  localparam logic [COUNT_BITS-1:0] STAT_ONE = COUNT_BITS'(1);

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_ARMED   = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [COORD_BITS-1:0]           r_x;
  logic [COORD_BITS-1:0]           r_y;
  logic [MULTICAST_GROUP_BITS-1:0] r_mcast;
  logic                            r_done;
  logic                            r_result;
  logic [MATRIX_TYPE_BITS-1:0]     r_type;
  logic [MATRIX_COORD_BITS-1:0]    r_mx;
  logic [MATRIX_COORD_BITS-1:0]    r_my;
  logic [MATRIX_ELEMENT_BITS-1:0]  r_elem;

  logic [PACKET_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]    r_wr_ptr;
  logic [PTR_BITS-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_next;
  logic                   r_valid;
  logic                   r_ready;

  logic [COUNT_BITS-1:0] r_sent;
  logic [COUNT_BITS-1:0] r_malformed;
  logic [COUNT_BITS-1:0] r_dropped;
  logic                  r_error;

  logic [PACKET_BITS-1:0] w_pkt;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_malformed;
  logic                   w_dropped;

  // Snapshot uses the registered fields, so same-cycle writes land on the next packet.
  assign w_pkt  = {r_x, r_y, r_mcast, r_done, r_result, r_type, r_mx, r_my, r_elem};
  assign w_full = (r_count == DEPTH_C);
  assign w_pop  = r_valid & pkt_out_ready;

  // Field registers: each loads on its own strobe and is otherwise sticky.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_mcast  <= '0;
      r_done   <= 1'b0;
      r_result <= 1'b0;
      r_type   <= '0;
      r_mx     <= '0;
      r_my     <= '0;
      r_elem   <= '0;
    end else begin
      if (x_coord_in_valid)         r_x      <= x_coord_in;
      if (y_coord_in_valid)         r_y      <= y_coord_in;
      if (multicast_group_in_valid) r_mcast  <= multicast_group_in;
      if (done_flag_in_valid)       r_done   <= done_flag_in;
      if (result_flag_in_valid)     r_result <= result_flag_in;
      if (matrix_type_in_valid)     r_type   <= matrix_type_in;
      if (matrix_x_coord_in_valid)  r_mx     <= matrix_x_coord_in;
      if (matrix_y_coord_in_valid)  r_my     <= matrix_y_coord_in;
      if (matrix_element_in_valid)  r_elem   <= matrix_element_in;
    end
  end

  // Collection state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Commit decode and next state; an element strobe always arms the following packet.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_malformed  = 1'b0;
    w_dropped    = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (packet_complete_in) begin
          w_malformed = 1'b1;
        end else begin
          w_malformed = 1'b0;
        end
      end
      S_ARMED: begin
        if (packet_complete_in) begin
          if (w_full && !w_pop) begin
            w_dropped = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end else begin
          w_push = 1'b0;
        end
      end
      default: begin
        w_state_next = S_COLLECT;
      end
    endcase
    if (matrix_element_in_valid) begin
      w_state_next = S_ARMED;
    end else if (packet_complete_in) begin
      w_state_next = S_COLLECT;
    end else begin
      w_state_next = w_state_next;
    end
  end

  // Next occupancy from the push/pop pair.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Packet FIFO storage, pointers and registered status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_pkt;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
      r_ready <= (w_count_next < DEPTH_C);
    end
  end

  // Saturating statistics and the sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sent      <= '0;
      r_malformed <= '0;
      r_dropped   <= '0;
      r_error     <= 1'b0;
    end else begin
      if (w_pop && (r_sent != '1)) begin
        r_sent <= r_sent + STAT_ONE;
      end
      if (w_malformed && (r_malformed != '1)) begin
        r_malformed <= r_malformed + STAT_ONE;
      end
      if (w_dropped && (r_dropped != '1)) begin
        r_dropped <= r_dropped + STAT_ONE;
      end
      if (w_malformed || w_dropped) begin
        r_error <= 1'b1;
      end
    end
  end

  assign message_out_ready = r_ready;
  assign pkt_out_valid     = r_valid;
  assign pkt_out_data      = r_mem[r_rd_ptr];
  assign sent_count        = r_sent;
  assign malformed_count   = r_malformed;
  assign dropped_count     = r_dropped;
  assign error             = r_error;

endmodule
